// File: rtl/game_controller_pkg.sv
// Shared definitions for the whack-a-mole game controller: state encoding,
// mole lifetime constants, LFSR seed and the difficulty-to-lifetime helper.
package game_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_UP   = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam logic [9:0]  LIFE_EASY_MS = 10'd1000;
  localparam logic [9:0]  LIFE_MED_MS  = 10'd600;
  localparam logic [9:0]  LIFE_HARD_MS = 10'd350;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;

  // Mole lifetime in ms for a difficulty code; code 3 plays like code 2.
  function automatic logic [9:0] lifetime_ms(input logic [1:0] diff);
    logic [9:0] life;
    case (diff)
      2'd0:    life = LIFE_EASY_MS;
      2'd1:    life = LIFE_MED_MS;
      default: life = LIFE_HARD_MS;
    endcase
    return life;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, stepping every cycle.
// Only the low nibble is exported since that is all the mole picker needs.
module lfsr16
  import game_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] lfsr_low
);

  logic [15:0] lfsr;

  // Shift right, feeding the tap XOR back into the top bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  assign lfsr_low = lfsr[3:0];

endmodule

// File: rtl/game_controller.sv
// Whack-a-mole round controller: IDLE -> GAP <-> UP -> OVER.
// Counts ms ticks for gap/lifetime timing and whole seconds for time_left.
// Optional build macro: MISS_PENALTY_EN (wrong-hole whack costs one point).
module game_controller
  import game_controller_pkg::*;
#(
  parameter int TICKS_PER_MS = 100000,
  parameter int GAP_MS       = 200
) (
  input  logic       CLK100MHZ,
  input  logic       rst,
  input  logic       gamestart,
  input  logic [5:0] gametime,
  input  logic [1:0] difficulty,
  input  logic       hit_valid,
  input  logic [3:0] hit_idx,
  output logic       mole_valid,
  output logic [3:0] mole_idx,
  output logic [5:0] time_left,
  output logic [7:0] score,
  output logic       game_over
);

  localparam int         TW        = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_MS - 1);
  localparam logic [9:0] GAP_LAST  = 10'(GAP_MS - 1);
  localparam logic [9:0] SEC_LAST  = 10'd999;

  state_t        state, state_nxt;
  logic [TW-1:0] tick_cnt, tick_cnt_nxt;
  logic [9:0]    phase_ms, phase_ms_nxt;   // ms spent in current GAP/UP phase
  logic [9:0]    sec_ms, sec_ms_nxt;       // ms into the current second
  logic [1:0]    diff, diff_nxt;
  logic          prev_start;
  logic          mole_valid_nxt;
  logic [3:0]    mole_idx_nxt;
  logic [5:0]    time_left_nxt;
  logic [7:0]    score_nxt;
  logic          game_over_nxt;

  logic          ms_tick;
  logic          sec_wrap;
  logic [9:0]    life_last;
  logic [3:0]    cand;
  logic [3:0]    lfsr_low;

  lfsr16 u_lfsr (
    .clk      (CLK100MHZ),
    .rst      (rst),
    .lfsr_low (lfsr_low)
  );

  // Next-state and next-output logic for the round FSM and its counters.
  always_comb begin
    state_nxt      = state;
    tick_cnt_nxt   = tick_cnt;
    phase_ms_nxt   = phase_ms;
    sec_ms_nxt     = sec_ms;
    diff_nxt       = diff;
    mole_valid_nxt = mole_valid;
    mole_idx_nxt   = mole_idx;
    time_left_nxt  = time_left;
    score_nxt      = score;
    game_over_nxt  = game_over;

    ms_tick   = (tick_cnt == TICK_LAST);
    sec_wrap  = ms_tick && (sec_ms == SEC_LAST);
    life_last = lifetime_ms(diff) - 10'd1;
    // Never repeat the hole of the previous mole.
    if (lfsr_low == mole_idx) begin
      cand = lfsr_low + 4'd1;
    end else begin
      cand = lfsr_low;
    end

    case (state)
      ST_IDLE: begin
        mole_valid_nxt = 1'b0;
        game_over_nxt  = 1'b0;
        if (gamestart && !prev_start && (gametime != 6'd0)) begin
          time_left_nxt = gametime;
          diff_nxt      = difficulty;
          score_nxt     = 8'd0;
          tick_cnt_nxt  = '0;
          phase_ms_nxt  = 10'd0;
          sec_ms_nxt    = 10'd0;
          state_nxt     = ST_GAP;
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      ST_GAP, ST_UP: begin
        if (!gamestart) begin
          // Abort: drop the mole, keep the score on display.
          mole_valid_nxt = 1'b0;
          state_nxt      = ST_IDLE;
        end else if (sec_wrap && (time_left == 6'd1)) begin
          // Round ends; any whack in this cycle is deliberately not scored.
          time_left_nxt  = 6'd0;
          mole_valid_nxt = 1'b0;
          game_over_nxt  = 1'b1;
          state_nxt      = ST_OVER;
        end else begin
          tick_cnt_nxt = ms_tick ? '0 : (tick_cnt + TW'(1));
          if (sec_wrap) begin
            sec_ms_nxt    = 10'd0;
            time_left_nxt = time_left - 6'd1;
          end else if (ms_tick) begin
            sec_ms_nxt = sec_ms + 10'd1;
          end else begin
            sec_ms_nxt = sec_ms;
          end
          if (ms_tick) begin
            phase_ms_nxt = phase_ms + 10'd1;
          end else begin
            phase_ms_nxt = phase_ms;
          end

          if (state == ST_GAP) begin
            if (ms_tick && (phase_ms == GAP_LAST)) begin
              mole_idx_nxt   = cand;
              mole_valid_nxt = 1'b1;
              phase_ms_nxt   = 10'd0;
              state_nxt      = ST_UP;
            end else begin
              state_nxt = ST_GAP;
            end
          end else begin
            if (hit_valid && (hit_idx == mole_idx)) begin
              if (score != 8'hFF) begin
                score_nxt = score + 8'd1;
              end else begin
                score_nxt = score;
              end
              mole_valid_nxt = 1'b0;
              phase_ms_nxt   = 10'd0;
              state_nxt      = ST_GAP;
            end else begin
`ifdef MISS_PENALTY_EN
              if (hit_valid && (score != 8'd0)) begin
                score_nxt = score - 8'd1;
              end else begin
                score_nxt = score;
              end
`else
              score_nxt = score;
`endif
              if (ms_tick && (phase_ms == life_last)) begin
                mole_valid_nxt = 1'b0;
                phase_ms_nxt   = 10'd0;
                state_nxt      = ST_GAP;
              end else begin
                state_nxt = ST_UP;
              end
            end
          end
        end
      end

      ST_OVER: begin
        mole_valid_nxt = 1'b0;
        if (!gamestart) begin
          game_over_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end else begin
          game_over_nxt = 1'b1;
        end
      end

      default: begin
        mole_valid_nxt = 1'b0;
        game_over_nxt  = 1'b0;
        state_nxt      = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered-output update with synchronous reset.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state      <= ST_IDLE;
      tick_cnt   <= '0;
      phase_ms   <= 10'd0;
      sec_ms     <= 10'd0;
      diff       <= 2'd0;
      prev_start <= 1'b0;
      mole_valid <= 1'b0;
      mole_idx   <= 4'd0;
      time_left  <= 6'd0;
      score      <= 8'd0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_nxt;
      tick_cnt   <= tick_cnt_nxt;
      phase_ms   <= phase_ms_nxt;
      sec_ms     <= sec_ms_nxt;
      diff       <= diff_nxt;
      prev_start <= gamestart;
      mole_valid <= mole_valid_nxt;
      mole_idx   <= mole_idx_nxt;
      time_left  <= time_left_nxt;
      score      <= score_nxt;
      game_over  <= game_over_nxt;
    end
  end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter TICKS_PER_MS, default 100000, SHALL set CLK100MHZ cycles per millisecond tick (benches use 2).
REQ-002 Parameter GAP_MS, default 200, SHALL set the empty interval in ms between moles.
REQ-003 CLK100MHZ  in  1  SHALL be the single system clock; all state on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 gamestart  in  1  SHALL be the run level from the button block (1 = run, 0 = stop/abort).
REQ-006 gametime  in  6  SHALL be the round length in seconds (0..60).
REQ-007 difficulty  in  2  SHALL select mole lifetime: 0 = 1000 ms, 1 = 600 ms, 2 = 350 ms, 3 = treated as 2.
REQ-008 hit_valid  in  1  SHALL be a one-cycle whack strobe.
REQ-009 hit_idx  in  4  SHALL be the hole whacked, valid with hit_valid.
REQ-010 mole_valid  out  1  SHALL be high while a mole is up.
REQ-011 mole_idx  out  4  SHALL be the current mole hole, held stable while mole_valid.
REQ-012 time_left  out  6  SHALL be the remaining seconds.
REQ-013 score  out  8  SHALL be the hit count.
REQ-014 game_over  out  1  SHALL be high in OVER state.

Function
REQ-015 States SHALL be IDLE, GAP, UP, OVER.
REQ-016 IDLE: on gamestart 0->1 with gametime != 0, SHALL latch gametime into time_left, latch difficulty, clear score and ms counters, enter GAP; gametime == 0 SHALL stay IDLE.
REQ-017 Difficulty and gametime changes SHALL be ignored outside IDLE.
REQ-018 A ms tick SHALL pulse every TICKS_PER_MS cycles while not IDLE/OVER; every 1000 ms ticks time_left SHALL decrement by 1.
REQ-019 GAP: after GAP_MS ms ticks SHALL load mole_idx and enter UP with mole_valid = 1 next cycle.
REQ-020 mole_idx SHALL be LFSR[3:0]; if equal to previous mole_idx, use (LFSR[3:0]+1) mod 16.
REQ-021 UP: hit_valid with hit_idx == mole_idx SHALL increment score (saturate 255), drop mole_valid next cycle, enter GAP.
REQ-022 UP: lifetime expiry without hit SHALL drop mole_valid and enter GAP, score unchanged.
REQ-023 hit_valid outside UP SHALL be ignored.
REQ-024 time_left reaching 0 from any running state SHALL enter OVER next cycle, mole_valid = 0; a hit in that same cycle SHALL NOT score.
REQ-025 OVER: score and time_left held; gamestart 0 SHALL return to IDLE.
REQ-026 gamestart 0 in GAP/UP SHALL abort to IDLE next cycle, mole_valid = 0, score held.

Reset
REQ-027 rst SHALL force IDLE, mole_valid = 0, mole_idx = 0, time_left = 0, score = 0, game_over = 0, all counters 0, LFSR = 16'hACE1, previous gamestart sample = 0.
REQ-028 rst SHALL override all other inputs in the same cycle, including mid-game.

Configuration
REQ-029 With MISS_PENALTY_EN defined, a UP-state hit_valid with hit_idx != mole_idx SHALL decrement score (saturate 0) with mole staying up; without it such hits SHALL be ignored.

Structure
REQ-030 Shared package SHALL hold the state encoding, lifetime constants (1000/600/350) and LFSR seed.
REQ-031 One sub-module, lfsr16 (x^16+x^14+x^13+x^11+1, advances every cycle), SHALL supply the random value.

Verification
REQ-032 gametime=5, diff=0, gamestart 0->1 -> GAP, first mole after 200 ms, time_left 5->0 over 5000 ms, game_over=1.
REQ-033 Correct hit at 100 ms into UP -> score 0->1, mole_valid low next cycle, next mole 200 ms later with different idx.
REQ-034 diff=2, no hits -> each mole up exactly 350 ms, score stays 0.
REQ-035 Wrong-hole hit with score=3 -> score 2 with MISS_PENALTY_EN, 3 without; wrong hit at score 0 -> 0.
REQ-036 Correct hit in same cycle time_left hits 0 -> OVER, score unchanged; gamestart 1->0 mid-UP -> IDLE, mole_valid 0; rst mid-game -> all outputs reset values.
REQ-037 gametime=0, gamestart 0->1 -> remains IDLE, outputs unchanged.
